ce_ls_mc: RTL and testbench

//  Multi-channel LS channel estimator, successor to the single-UE LS stage.

---
 rtl/ce_ls_mc.sv | 161 ++++++++++++++++
 tb/tb_ce_ls_mc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ce_ls_mc.sv
// ce_ls_mc: multi-channel LS channel estimator, H = Y * conj(X_ref) >>> SHIFT, saturated, 4-stage pipeline.
// Build option CE_LS_MC_ROUND_EN: round half up before the shift; without it the shift floors.
module ce_ls_mc #(
  parameter int wDataIn  = 16,
  parameter int wDataOut = 16,
  parameter int wCoeff   = 18,
  parameter int NCHAN    = 4,
  parameter int MAX_PTS  = 2048,
  parameter int SHIFT    = 16,
  localparam int wChan   = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int wAddr   = $clog2(MAX_PTS)
) (
  input  logic                       clk,
  input  logic                       rst_n_sync,
  input  logic                       sink_valid,
  output logic                       sink_ready,
  input  logic                       sink_sop,
  input  logic                       sink_eop,
  input  logic signed [wDataIn-1:0]  sink_real,
  input  logic signed [wDataIn-1:0]  sink_imag,
  input  logic [wChan-1:0]           sink_chan,
  input  logic [11:0]                fftpts_in,
  input  logic                       coef_wr_en,
  input  logic [wChan-1:0]           coef_wr_chan,
  input  logic [wAddr-1:0]           coef_wr_addr,
  input  logic signed [wCoeff-1:0]   coef_wr_real,
  input  logic signed [wCoeff-1:0]   coef_wr_imag,
  output logic                       source_valid,
  input  logic                       source_ready,
  output logic                       source_sop,
  output logic                       source_eop,
  output logic [1:0]                 source_error,
  output logic signed [wDataOut-1:0] source_real,
  output logic signed [wDataOut-1:0] source_imag,
  output logic [11:0]                fftpts_out
);
  // state   | meaning
  // ST_IDLE | waiting for sop; beats without sop are dropped
  // ST_PKT  | inside a packet; each accepted beat advances idx
  typedef enum logic {ST_IDLE, ST_PKT} state_t;

  localparam int wIdx  = wAddr + 2;
  localparam int wProd = wDataIn + wCoeff;
  localparam int wSum  = wProd + 1;
  localparam int wSide = 16;
`ifdef CE_LS_MC_ROUND_EN
  localparam logic signed [wSum-1:0] RND = wSum'(64'sd1 <<< (SHIFT - 1));
`else
  localparam logic signed [wSum-1:0] RND = '0;
`endif
  localparam logic signed [wSum-1:0] SAT_HI = wSum'((64'sd1 <<< (wDataOut - 1)) - 64'sd1);
  localparam logic signed [wSum-1:0] SAT_LO = wSum'(-(64'sd1 <<< (wDataOut - 1)));

  state_t                   r_state;
  logic [wChan-1:0]         r_chan;
  logic [wIdx-1:0]          r_idx;
  logic [11:0]              r_pts;
  logic [2*wCoeff-1:0]      r_mem [NCHAN*MAX_PTS];
  logic [2*wCoeff-1:0]      r_coef;
  logic                     r_v1, r_v2, r_v3;
  logic [wSide-1:0]         r_side1, r_side2, r_side3;
  logic signed [wDataIn-1:0] r_yr1, r_yi1;
  logic signed [wProd-1:0]  r_p_rr, r_p_ii, r_p_ir, r_p_ri;
  logic signed [wSum-1:0]   r_re3, r_im3;

  logic                     w_en, w_acc, w_in_pkt, w_keep, w_ovr;
  logic [wChan-1:0]         w_chan_eff;
  logic [wIdx-1:0]          w_idx_eff, w_cnt;
  logic [11:0]              w_pts_eff;
  logic [1:0]               w_err;
  logic [wAddr-1:0]         w_addr;
  logic signed [wCoeff-1:0] w_cr, w_ci;
  logic signed [wSum-1:0]   w_re_sh, w_im_sh;

  assign w_en       = source_ready | ~source_valid;
  assign sink_ready = w_en;
  assign w_acc      = sink_valid & w_en;
  assign w_in_pkt   = (r_state == ST_PKT);
  // a sop beat uses its own chan/length and restarts at idx 0, even mid-packet
  assign w_chan_eff = sink_sop ? sink_chan : r_chan;
  assign w_idx_eff  = sink_sop ? '0 : r_idx;
  assign w_pts_eff  = sink_sop ? fftpts_in : r_pts;
  assign w_keep     = w_acc & (sink_sop | w_in_pkt);
  assign w_cnt      = w_idx_eff + wIdx'(1);
  assign w_ovr      = (w_idx_eff >= wIdx'(MAX_PTS));
  assign w_err      = {w_ovr | (sink_eop & (w_cnt != wIdx'(w_pts_eff))), sink_sop & w_in_pkt};
  assign w_addr     = w_ovr ? wAddr'(MAX_PTS - 1) : w_idx_eff[wAddr-1:0];
  assign w_cr       = r_coef[2*wCoeff-1:wCoeff];
  assign w_ci       = r_coef[wCoeff-1:0];
  assign w_re_sh    = (r_re3 + RND) >>> SHIFT;
  assign w_im_sh    = (r_im3 + RND) >>> SHIFT;

  function automatic logic [wDataOut-1:0] f_sat(input logic signed [wSum-1:0] v);
    if (v > SAT_HI)      f_sat = SAT_HI[wDataOut-1:0];
    else if (v < SAT_LO) f_sat = SAT_LO[wDataOut-1:0];
    else                 f_sat = v[wDataOut-1:0];
  endfunction

  // Coefficient RAM: read-before-write on a same-address collision
  always_ff @(posedge clk) begin
    if (coef_wr_en) r_mem[{coef_wr_chan, coef_wr_addr}] <= {coef_wr_real, coef_wr_imag};
    if (w_en) r_coef <= r_mem[{w_chan_eff, w_addr}];
  end

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      r_state <= ST_IDLE;
      r_chan  <= '0;
      r_idx   <= '0;
      r_pts   <= '0;
      r_v1    <= 1'b0;
      r_side1 <= '0;
      r_yr1   <= '0;
      r_yi1   <= '0;
    end else if (w_en) begin
      r_v1    <= w_keep;
      r_side1 <= {sink_sop, sink_eop, w_err, w_pts_eff};
      r_yr1   <= sink_real;
      r_yi1   <= sink_imag;
      if (w_keep) begin
        r_chan  <= w_chan_eff;
        r_pts   <= w_pts_eff;
        r_idx   <= (&w_idx_eff) ? w_idx_eff : w_cnt;
        r_state <= sink_eop ? ST_IDLE : ST_PKT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      r_v2 <= 1'b0; r_side2 <= '0;
      r_p_rr <= '0; r_p_ii <= '0; r_p_ir <= '0; r_p_ri <= '0;
      r_v3 <= 1'b0; r_side3 <= '0; r_re3 <= '0; r_im3 <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_error <= '0;
      source_real  <= '0;
      source_imag  <= '0;
      fftpts_out   <= '0;
    end else if (w_en) begin
      r_v2    <= r_v1;
      r_side2 <= r_side1;
      r_p_rr  <= wProd'(r_yr1) * wProd'(w_cr);
      r_p_ii  <= wProd'(r_yi1) * wProd'(w_ci);
      r_p_ir  <= wProd'(r_yi1) * wProd'(w_cr);
      r_p_ri  <= wProd'(r_yr1) * wProd'(w_ci);
      r_v3    <= r_v2;
      r_side3 <= r_side2;
      r_re3   <= wSum'(r_p_rr) + wSum'(r_p_ii);
      r_im3   <= wSum'(r_p_ir) - wSum'(r_p_ri);
      source_valid <= r_v3;
      source_sop   <= r_v3 & r_side3[15];
      source_eop   <= r_v3 & r_side3[14];
      source_error <= r_v3 ? r_side3[13:12] : 2'b00;
      source_real  <= f_sat(w_re_sh);
      source_imag  <= f_sat(w_im_sh);
      fftpts_out   <= r_side3[11:0];
    end
  end
endmodule

// File: tb/tb_ce_ls_mc.sv
// tb_ce_ls_mc: directed vectors for ce_ls_mc; expected beats come from a bench-side framing and arithmetic model.
// Honours CE_LS_MC_ROUND_EN the same way as the design.
module tb_ce_ls_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_sync, sink_valid, sink_ready, sink_sop, sink_eop;
  logic signed [15:0] sink_real, sink_imag;
  logic [1:0]  sink_chan;
  logic [11:0] fftpts_in;
  logic        coef_wr_en;
  logic [1:0]  coef_wr_chan;
  logic [10:0] coef_wr_addr;
  logic signed [17:0] coef_wr_real, coef_wr_imag;
  logic source_valid, source_ready, source_sop, source_eop;
  logic [1:0]  source_error;
  logic signed [15:0] source_real, source_imag;
  logic [11:0] fftpts_out;

  ce_ls_mc dut (
    .clk(clk), .rst_n_sync(rst_n_sync),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .sink_chan(sink_chan), .fftpts_in(fftpts_in),
    .coef_wr_en(coef_wr_en), .coef_wr_chan(coef_wr_chan), .coef_wr_addr(coef_wr_addr),
    .coef_wr_real(coef_wr_real), .coef_wr_imag(coef_wr_imag),
    .source_valid(source_valid), .source_ready(source_ready), .source_sop(source_sop),
    .source_eop(source_eop), .source_error(source_error), .source_real(source_real),
    .source_imag(source_imag), .fftpts_out(fftpts_out)
  );

  typedef struct {
    logic [15:0] re, im;
    logic sop, eop;
    logic [1:0] err;
    logic [11:0] pts;
    int cyc;
  } beat_t;

  beat_t got[$], exp_q[$];
  int n_chk = 0, n_pass = 0, cyc = 0, acc_cyc = 0;
  int sh_r[4][2048], sh_i[4][2048];
  bit m_inpkt = 1'b0;
  int m_chan = 0, m_idx = 0, m_pts = 0;
  bit pw_en = 1'b0;
  int pw_chan, pw_addr, pw_r, pw_i;

`ifdef CE_LS_MC_ROUND_EN
  localparam logic [15:0] T1_RE = 16'd1000;
`else
  localparam logic [15:0] T1_RE = 16'd999;
`endif

  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (rst_n_sync && sink_valid && sink_ready) acc_cyc = cyc;
    if (rst_n_sync && source_valid && source_ready) begin
      b.re = source_real; b.im = source_imag; b.sop = source_sop; b.eop = source_eop;
      b.err = source_error; b.pts = fftpts_out; b.cyc = cyc;
      got.push_back(b);
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, req);
  endtask

  function automatic logic [15:0] est(input int yr, input int yi, input int cr, input int ci, input bit im);
    longint v;
    v = im ? (longint'(yi) * longint'(cr) - longint'(yr) * longint'(ci))
           : (longint'(yr) * longint'(cr) + longint'(yi) * longint'(ci));
`ifdef CE_LS_MC_ROUND_EN
    v = v + 64'sd32768;
`endif
    v = v >>> 16;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  function automatic logic [63:0] pk(input beat_t b);
    return {16'h0, b.re, b.im, b.sop, b.eop, b.err, b.pts};
  endfunction

  task automatic compare_q(input string tag);
    int n;
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_%0d", tag, i), pk(got[i]), pk(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic wr(input int chan, input int addr, input int r, input int i);
    coef_wr_en = 1'b1; coef_wr_chan = 2'(chan); coef_wr_addr = 11'(addr);
    coef_wr_real = 18'(r); coef_wr_imag = 18'(i);
    @(posedge clk); #1;
    coef_wr_en = 1'b0;
    sh_r[chan][addr] = r; sh_i[chan][addr] = i;
  endtask

  // Drives one beat, predicts its output from the model, returns just after it is accepted.
  task automatic send(input bit sop, input bit eop, input int chan, input int pts, input int yr, input int yi);
    beat_t b;
    int a, n;
    sink_valid = 1'b1; sink_sop = sop; sink_eop = eop; sink_chan = 2'(chan);
    fftpts_in = 12'(pts); sink_real = 16'(yr); sink_imag = 16'(yi);
    if (pw_en) begin
      coef_wr_en = 1'b1; coef_wr_chan = 2'(pw_chan); coef_wr_addr = 11'(pw_addr);
      coef_wr_real = 18'(pw_r); coef_wr_imag = 18'(pw_i);
    end
    b.err = 2'b00;
    if (sop) begin
      b.err[0] = m_inpkt; m_chan = chan; m_idx = 0; m_pts = pts & 12'hFFF;
    end
    if (sop || m_inpkt) begin
      a = (m_idx > 2047) ? 2047 : m_idx;
      b.re = est(yr, yi, sh_r[m_chan][a], sh_i[m_chan][a], 1'b0);
      b.im = est(yr, yi, sh_r[m_chan][a], sh_i[m_chan][a], 1'b1);
      b.sop = sop; b.eop = eop; b.pts = 12'(m_pts); b.cyc = 0;
      b.err[1] = (m_idx >= 2048) || (eop && (m_idx + 1 != m_pts));
      exp_q.push_back(b);
      m_idx++;
      m_inpkt = !eop;
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (sink_ready) break;
      n++;
      if (n > 50) begin
        chk("sink_ready_timeout", 64'(0), 64'(1));
        break;
      end
    end
    @(posedge clk); #1;
    if (pw_en) begin
      sh_r[pw_chan][pw_addr] = pw_r; sh_i[pw_chan][pw_addr] = pw_i;
      coef_wr_en = 1'b0; pw_en = 1'b0;
    end
  endtask

  function automatic int yr_of(input int k);
    return ((k * 97) % 20000) - 10000;
  endfunction
  function automatic int yi_of(input int k);
    return 5000 - ((k * 53) % 9000);
  endfunction

  task automatic pkt(input int chan, input int pts, input int n);
    for (int k = 0; k < n; k++) send(k == 0, k == n - 1, chan, pts, yr_of(k), yi_of(k));
  endtask

  task automatic drain();
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n_sync = 1'b0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    sink_real = '0; sink_imag = '0; sink_chan = '0; fftpts_in = '0;
    coef_wr_en = 1'b0; coef_wr_chan = '0; coef_wr_addr = '0; coef_wr_real = '0; coef_wr_imag = '0;
    source_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sink_ready", 64'(sink_ready), 64'(1));
    chk("rst_source_valid", 64'(source_valid), 64'(0));
    chk("rst_outputs", 64'({source_sop, source_eop, source_error, source_real, source_imag, fftpts_out}), 64'(0));
    rst_n_sync = 1'b1;

    // conjugate multiply with rounding, plus exact latency
    wr(1, 0, 65535, 0);
    send(1'b1, 1'b1, 1, 1, 1000, -500);
    drain();
    chk("t1_count", 64'(got.size()), 64'(1));
    if (got.size() > 0) begin
      chk("t1_re", 64'(got[0].re), 64'(T1_RE));
      chk("t1_im", 64'(got[0].im), 64'(16'hFE0C));
      chk("t1_latency", 64'(got[0].cyc - acc_cyc), 64'(4));
    end
    compare_q("t1");

    wr(1, 0, 0, 65535);
    send(1'b1, 1'b1, 1, 1, 1000, 0);
    drain();
    chk("t2_count", 64'(got.size()), 64'(1));
    if (got.size() > 0) chk("t2_reim", 64'({got[0].re, got[0].im}), 64'({16'd0, 16'hFC18}));
    compare_q("t2");

    wr(1, 0, 65535, -65535);
    send(1'b1, 1'b1, 1, 1, 32767, 32767);
    drain();
    chk("t3_count", 64'(got.size()), 64'(1));
    if (got.size() > 0) chk("t3_sat", 64'({got[0].re, got[0].im}), 64'({16'd0, 16'd32767}));
    compare_q("t3");

    // backpressure mid-stream
    for (int k = 0; k < 8; k++) wr(2, k, 4096 * (k + 1), -2048 * k);
    fork
      pkt(2, 8, 8);
      begin
        repeat (6) @(posedge clk);
        #1 source_ready = 1'b0;
        @(negedge clk);
        chk("bp_sink_ready_low", 64'(sink_ready), 64'(0));
        repeat (4) @(negedge clk);
        chk("bp_hold_valid", 64'(source_valid), 64'(1));
        chk("bp_hold_data", 64'({source_real, source_imag}), 64'({exp_q[2].re, exp_q[2].im}));
        @(posedge clk);
        #1 source_ready = 1'b1;
      end
    join
    drain();
    compare_q("bp");

    // framing: short packet, sop mid-packet, reset mid-packet, beat in IDLE
    pkt(2, 8, 6);
    drain();
    compare_q("short_eop");
    send(1'b1, 1'b0, 2, 8, 111, 222);
    send(1'b0, 1'b0, 2, 8, 333, -444);
    send(1'b1, 1'b0, 2, 3, -555, 666);
    send(1'b0, 1'b0, 2, 3, 777, 888);
    send(1'b0, 1'b1, 2, 3, -999, -1111);
    drain();
    compare_q("mid_sop");
    send(1'b1, 1'b0, 2, 8, 1200, 1300);
    send(1'b0, 1'b0, 2, 8, 1400, 1500);
    sink_valid = 1'b0;
    rst_n_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n_sync = 1'b1;
    exp_q.delete();
    m_inpkt = 1'b0;
    drain();
    compare_q("rst_flush");
    send(1'b0, 1'b0, 2, 8, 1600, 1700);
    drain();
    compare_q("idle_drop");

    // channel select, live writes and read-old-data collision
    for (int k = 0; k < 8; k++) wr(0, k, 60000 - 5000 * k, 3000 * k);
    for (int a = 0; a < 2048; a++) wr(3, a, 1000 + 37 * a, -(500 + 11 * a));
    pkt(0, 8, 8);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin pw_en = 1'b1; pw_chan = 0; pw_addr = 0; pw_r = -40000; pw_i = 12345; end
      if (k == 4) begin pw_en = 1'b1; pw_chan = 3; pw_addr = 4; pw_r = 5; pw_i = 6; end
      send(k == 0, k == 7, 3, 8, yr_of(k + 11), yi_of(k + 11));
    end
    drain();
    compare_q("chan");
    send(1'b1, 1'b1, 0, 1, 1234, -4321);
    drain();
    compare_q("live_wr");

    // index past MAX_PTS: clamped address and length error
    pkt(3, 2050, 2050);
    drain();
    compare_q("overlong");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
